imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width of the data word and the memory address.
REQ-002 SHALL have parameter DEPTH, default 64, meaning the instruction memory size in words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit, an asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, a load request that is sampled every cycle.
REQ-006 SHALL have port len, input, 7 bits, the number of words to load, sampled when start is accepted.
REQ-007 SHALL have port byte_valid, input, 1 bit, meaning the stream byte is valid.
REQ-008 SHALL have port byte_data, input, 8 bits, the stream byte.
REQ-009 SHALL have port byte_ready, output, 1 bit; a byte is accepted only when byte_valid and byte_ready are both high.
REQ-010 SHALL have port mem_we, output, 1 bit, the instruction-memory write enable.
REQ-011 SHALL have port mem_addr, output, WIDTH bits, a word-aligned byte address.
REQ-012 SHALL have port mem_wd, output, WIDTH bits, the instruction-memory write data.
REQ-013 SHALL have port core_hold, output, 1 bit; when high, the processor is held in reset.
REQ-014 SHALL have port busy, output, 1 bit, high while the state is RECV or WRITE.
REQ-015 SHALL have port done, output, 1 bit, high in the DONE state.
REQ-016 SHALL have port err, output, 1 bit, a sticky flag for a bad length.
REQ-017 SHALL have port checksum, output, WIDTH bits, the XOR of all words written in the current load.

Function
REQ-018 SHALL implement the FSM states IDLE, RECV, WRITE and DONE.
REQ-019 SHALL define a valid len as 1 <= len <= DEPTH.
REQ-020 In IDLE or DONE, start with a valid len SHALL move the FSM to RECV and perform the load-start actions:
- capture len;
- clear the word index, the byte index and checksum;
- clear err;
- assert core_hold.
REQ-021 In IDLE or DONE, start with an invalid len SHALL set err=1 and SHALL leave the state, core_hold, checksum and memory unchanged.
REQ-022 start SHALL be ignored in RECV and WRITE.
REQ-023 byte_ready SHALL be 1 only in RECV.
REQ-024 In RECV, each accepted byte SHALL be placed little-endian into the assembly word:
- byte index 0 goes to bits 7:0;
- byte index 3 goes to bits 31:24.
REQ-025 In RECV, acceptance of the 4th byte SHALL move the FSM to WRITE on the next edge.
REQ-026 In RECV, cycles with byte_valid=0 SHALL cause no change of state.
REQ-027 WRITE SHALL last exactly one cycle, with:
- mem_we=1;
- mem_addr = word_index*4;
- mem_wd = the assembled word.
REQ-028 At the end of WRITE, checksum SHALL be XORed with mem_wd and the word index SHALL be incremented.
REQ-029 At the end of WRITE, the next state SHALL be DONE if the word just written was index len-1, otherwise RECV.
REQ-030 mem_we SHALL be 0 in every state other than WRITE.
REQ-031 mem_addr and mem_wd SHALL hold their last written values when mem_we=0.
REQ-032 The minimum latency SHALL be 5 cycles per word: 4 accept cycles plus 1 write cycle.
REQ-033 A full load SHALL take at least 5*len cycles from the first accepted byte to entry into DONE.
REQ-034 In DONE, core_hold SHALL be 0, done SHALL be 1 and busy SHALL be 0.
REQ-035 In DONE, done, checksum and the memory outputs SHALL hold their values until the next accepted start.
REQ-036 Word-index arithmetic SHALL be unsigned.
REQ-037 The word index SHALL never exceed DEPTH-1; there is no wrap-around within a load.

Reset
REQ-038 When areset=1, the block SHALL immediately (asynchronously) enter IDLE and drive:
- byte_ready=0, mem_we=0, mem_addr=0, mem_wd=0;
- core_hold=1, busy=0, done=0, err=0, checksum=0;
- internal indices and the assembly word = 0.
REQ-039 A reset in the middle of a load SHALL abort the load with no further memory writes.
REQ-040 After a reset, no write SHALL occur until a new valid start is accepted.

Verification
REQ-041 Reset test: assert areset mid-cycle -> all outputs take their REQ-038 values without waiting for a clk edge.
REQ-042 Two-word load test: start with len=2, then bytes 13 05 00 00 93 00 50 00 streamed with byte_valid held high. Required response:
- writes of (addr 0, data 0x00000513) and then (addr 4, data 0x00500093), each a single-cycle mem_we pulse;
- done=1 and core_hold=0 after 10 byte-stream cycles;
- checksum=0x00500580.
REQ-043 Backpressure test: len=1, with byte_valid low for 3 cycles between each byte -> a single write of the correct word, and no write before the 4th byte is accepted.
REQ-044 Bad-length test: start with len=0 -> err=1, state stays IDLE, byte_ready=0. Then start with len=65 -> err remains 1. Then start with len=1 -> err=0 and busy=1.
REQ-045 Abort test: assert areset after 2 bytes of word 0 are accepted -> no mem_we pulse, core_hold=1, state IDLE.
REQ-046 Restart test: pulse start during RECV -> it is ignored. After DONE, start with len=1 -> core_hold=1, checksum=0, busy=1, and the next write goes to addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Purpose: assemble a little-endian byte stream into words and write them to instruction memory while holding the core.
// Latency: 4 byte-accept cycles + 1 write cycle per word; DONE is entered on the edge that ends the last write.
// Backpressure: byte_ready is high only while collecting bytes; it drops for the single write cycle and outside a load.
//
// Ports:
//   clk, areset                    clock and asynchronous active-high reset
//   start, len                     load request and word count (valid range 1..DEPTH), honoured only when idle or done
//   byte_valid, byte_data, byte_ready   byte stream handshake
//   mem_we, mem_addr, mem_wd       instruction-memory write port (address/data hold between writes)
//   core_hold, busy, done, err     processor hold, load in progress, load complete, sticky bad-length flag
//   checksum                       XOR of every word written in the current load
module imem_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic [6:0]       len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] checksum
);

  // len is only 7 bits wide, so any DEPTH above 127 cannot be reached anyway.
  localparam int unsigned DMAX    = (DEPTH > 127) ? 127 : DEPTH;
  localparam logic [6:0]  LEN_MAX = 7'(DMAX);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state, state_nx;
  logic [6:0]       len_q;
  logic [6:0]       word_idx;
  logic [1:0]       byte_idx;
  logic [WIDTH-1:0] asm_word;
  logic [WIDTH-1:0] asm_nx;
  logic             len_ok;
  logic             start_ok;
  logic             start_bad;
  logic             accept;
  logic             last_word;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and status outputs
  always_comb begin
    len_ok     = (len != 7'd0) && (len <= LEN_MAX);
    start_ok   = start && len_ok && ((state == IDLE) || (state == DONE));
    start_bad  = start && !len_ok && ((state == IDLE) || (state == DONE));
    accept     = (state == RECV) && byte_valid;
    last_word  = (word_idx == (len_q - 7'd1));

    asm_nx = asm_word;
    asm_nx[{byte_idx, 3'b000} +: 8] = byte_data;

    state_nx   = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    core_hold  = 1'b1;

    case (state)
      IDLE: begin
        if (start_ok) state_nx = RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (accept && (byte_idx == 2'd3)) state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        busy     = 1'b1;
        state_nx = last_word ? DONE : RECV;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start_ok) state_nx = RECV;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: indices, assembly word, write port registers, checksum, error flag.
  // mem_addr/mem_wd are loaded as the 4th byte is taken so they are valid during
  // the WRITE cycle and simply hold afterwards.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
      checksum <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            len_q    <= len;
            word_idx <= '0;
            byte_idx <= '0;
            checksum <= '0;
            err      <= 1'b0;
          end else if (start_bad) begin
            err <= 1'b1;
          end
        end
        RECV: begin
          if (accept) begin
            asm_word <= asm_nx;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_addr <= WIDTH'({word_idx, 2'b00});
              mem_wd   <= asm_nx;
            end
          end
        end
        WRITE: begin
          checksum <= checksum ^ mem_wd;
          // Stop at the last word so the index never points past the memory.
          if (!last_word) word_idx <= word_idx + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             areset;
  logic             start = 1'b0;
  logic [6:0]       len = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready, mem_we, core_hold, busy, done, err;
  logic [WIDTH-1:0] mem_addr, mem_wd, checksum;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit poke_en = 1'b0;
  logic [63:0] wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a load is "active" from an accepted start until
  // len words have been written; every 4th accepted byte yields exactly one write
  // in the following cycle, during which no byte is taken.
  bit          m_loading, m_done, m_err, m_we;
  int          m_len, m_bytes, m_writes;
  logic [31:0] m_word, m_addr, m_wd, m_chk;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_loading = 0; m_done = 0; m_err = 0; m_we = 0;
      m_len = 0; m_bytes = 0; m_writes = 0;
      m_word = 0; m_addr = 0; m_wd = 0; m_chk = 0;
    end else if (m_we) begin
      m_chk = m_chk ^ m_wd;
      m_writes++;
      m_we = 0;
      if (m_writes == m_len) begin
        m_loading = 0;
        m_done = 1;
      end
    end else if (m_loading) begin
      if (byte_valid) begin
        m_word[8*(m_bytes%4) +: 8] = byte_data;
        m_bytes++;
        if (m_bytes % 4 == 0) begin
          m_we = 1;
          m_addr = 32'(4 * (m_bytes/4 - 1));
          m_wd = m_word;
        end
      end
    end else if (start) begin
      if (int'(len) >= 1 && int'(len) <= DEPTH) begin
        m_loading = 1; m_done = 0; m_err = 0;
        m_len = int'(len); m_bytes = 0; m_writes = 0; m_chk = 0;
      end else begin
        m_err = 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("mem_we", mem_we, m_we);
    check("byte_ready", byte_ready, m_loading && !m_we);
    check("busy", busy, m_loading);
    check("done", done, m_done);
    check("core_hold", core_hold, m_loading || !m_done);
    check("err", err, m_err);
    check("checksum", checksum, m_chk);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wd", mem_wd, m_wd);
    if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wd});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len = 7'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap, input bit keep);
    int n;
    bit ok;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      if (poke_en) begin
        start = ($urandom_range(0, 3) == 0);
        len = 7'($urandom_range(0, 127));
      end
      tick();
      start = 1'b0;
    end
    byte_valid = 1'b1;
    byte_data = b;
    n = 0;
    do begin
      ok = byte_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    check("byte_accept", ok, 1'b1);
    last_acc_cyc = cyc;
    if (!keep) byte_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8], gap, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".byte_ready"}, byte_ready, 1'b0);
    check({tag, ".mem_we"}, mem_we, 1'b0);
    check({tag, ".mem_addr"}, mem_addr, 32'h0);
    check({tag, ".mem_wd"}, mem_wd, 32'h0);
    check({tag, ".core_hold"}, core_hold, 1'b1);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".err"}, err, 1'b0);
    check({tag, ".checksum"}, checksum, 32'h0);
  endtask

  task automatic pulse_reset();
    #2 areset = 1'b1;
    tick();
    #3 areset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, c0, l;
    logic [7:0] s[8];

    // Reset: values appear asynchronously, before any clock edge.
    areset = 1'b0;
    #1 areset = 1'b1;
    #2 check_reset("reset");
    tick();
    tick();
    #3 areset = 1'b0;
    tick();

    // Two-word load with byte_valid held high.
    s = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    w0 = wlog.size();
    do_start(2);
    push_byte(s[0], 0, 1'b1);
    c0 = last_acc_cyc;
    for (int i = 1; i < 8; i++) push_byte(s[i], 0, 1'b1);
    byte_valid = 1'b0;
    wait_done();
    check("two.latency", 32'(cyc - c0), 32'd9);
    check("two.nwrites", 32'(wlog.size() - w0), 32'd2);
    check("two.addr0", wlog[w0][63:32], 32'h0);
    check("two.data0", wlog[w0][31:0], 32'h00000513);
    check("two.addr1", wlog[w0+1][63:32], 32'h4);
    check("two.data1", wlog[w0+1][31:0], 32'h00500093);
    check("two.checksum", checksum, 32'h00500580);
    check("two.core_hold", core_hold, 1'b0);

    // Backpressure: 3 idle cycles before each byte.
    w0 = wlog.size();
    do_start(1);
    push_byte(8'h78, 3, 1'b0);
    push_byte(8'h56, 3, 1'b0);
    push_byte(8'h34, 3, 1'b0);
    check("bp.nowrite_early", 32'(wlog.size() - w0), 32'd0);
    push_byte(8'h12, 3, 1'b0);
    wait_done();
    check("bp.nwrites", 32'(wlog.size() - w0), 32'd1);
    check("bp.addr", wlog[w0][63:32], 32'h0);
    check("bp.data", wlog[w0][31:0], 32'h12345678);

    // Bad lengths from IDLE.
    pulse_reset();
    do_start(0);
    check("bad0.err", err, 1'b1);
    check("bad0.busy", busy, 1'b0);
    check("bad0.byte_ready", byte_ready, 1'b0);
    check("bad0.core_hold", core_hold, 1'b1);
    do_start(65);
    check("bad65.err", err, 1'b1);
    do_start(64);
    check("max.err", err, 1'b0);
    check("max.busy", busy, 1'b1);
    for (int i = 0; i < 64; i++) load_word($urandom, 0);
    wait_done();
    check("max.last_addr", mem_addr, 32'd252);
    do_start(0);
    check("bad_in_done.err", err, 1'b1);
    check("bad_in_done.done", done, 1'b1);
    do_start(1);
    check("ok1.err", err, 1'b0);
    check("ok1.busy", busy, 1'b1);
    load_word(32'hCAFEF00D, 1);
    wait_done();

    // Abort after two bytes of word 0.
    pulse_reset();
    w0 = wlog.size();
    do_start(2);
    push_byte(8'hAA, 0, 1'b0);
    push_byte(8'hBB, 0, 1'b0);
    #2 areset = 1'b1;
    #1 check_reset("abort");
    tick();
    #3 areset = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_data = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    check("abort.nwrites", 32'(wlog.size() - w0), 32'd0);
    check("abort.core_hold", core_hold, 1'b1);
    check("abort.byte_ready", byte_ready, 1'b0);

    // Restart: start during RECV is ignored, start after DONE reloads.
    w0 = wlog.size();
    do_start(2);
    push_byte(8'h01, 0, 1'b0);
    push_byte(8'h02, 0, 1'b0);
    do_start(5);
    push_byte(8'h03, 0, 1'b0);
    push_byte(8'h04, 0, 1'b0);
    load_word(32'h11223344, 0);
    wait_done();
    check("restart.nwrites", 32'(wlog.size() - w0), 32'd2);
    check("restart.data0", wlog[w0][31:0], 32'h04030201);
    do_start(1);
    check("restart.core_hold", core_hold, 1'b1);
    check("restart.checksum", checksum, 32'h0);
    check("restart.busy", busy, 1'b1);
    load_word(32'h0BADBEEF, 0);
    wait_done();
    check("restart.addr", wlog[wlog.size()-1][63:32], 32'h0);

    // Randomized loads with gaps, ignored start pokes and invalid lengths.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       l = $urandom_range(62, 70);
        1:       l = $urandom_range(0, 127);
        default: l = $urandom_range(1, 6);
      endcase
      do_start(l);
      if (l >= 1 && l <= DEPTH) begin
        poke_en = 1'b1;
        for (int wd = 0; wd < l; wd++)
          for (int b = 0; b < 4; b++)
            push_byte(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 1) == 1);
        poke_en = 1'b0;
        byte_valid = 1'b0;
        wait_done();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
